shift_exec_stage: RTL and testbench

SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

---
 rtl/shift_exec_pkg.sv | 7 +
 rtl/shift_exec_stage_shift_core.sv | 19 +
 rtl/shift_exec_stage.sv | 87 ++++++++
 tb/tb_shift_exec_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/shift_exec_pkg.sv
// shift_exec_pkg: shared op and occupancy encodings for the shift execute stage
package shift_exec_pkg;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;
   typedef enum logic [1:0] {ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRL = 2'b11} shift_op_e;
   typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10} occ_e;
endpackage

// File: rtl/shift_exec_stage_shift_core.sv
// shift_core: combinational 16-bit rotate/shift unit
module shift_core
   import shift_exec_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [CNT_W-1:0]  cnt,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] result
);
   logic [4:0] inv;
   // a count of zero shifts the wrap-around half by 16, which clears it and leaves data unchanged
   always_comb begin
      inv    = 5'd16 - {1'b0, cnt};
      result = (op == ROL) ? ((data << cnt) | (data >> inv)) :
               (op == SLL) ? (data << cnt) :
               (op == ROR) ? ((data >> cnt) | (data << inv)) :
                             (data >> cnt);
   end
endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: shift execute stage with a 2-entry skid buffer on its result
module shift_exec_stage
   import shift_exec_pkg::*;
#(
   parameter int TAG_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_data,
   input  logic [3:0]        in_cnt,
   input  logic [1:0]        in_op,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data,
   output logic [TAG_W-1:0]  out_tag
);
   occ_e             state_q, state_d;
   logic [15:0]      main_data_q, main_data_d, skid_data_q, skid_data_d, res;
   logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
   logic             in_ready_q, in_ready_d, accept, drain;

   shift_core u_core (.data(in_data), .cnt(in_cnt), .op(in_op), .result(res));

   assign in_ready  = in_ready_q;
   assign out_valid = state_q != EMPTY;
   assign out_data  = main_data_q;
   assign out_tag   = main_tag_q;

   // occupancy transitions; flush empties the buffer but the concurrent drain still counts downstream
   always_comb begin
      accept      = in_valid && in_ready_q;
      drain       = out_valid && out_ready;
      state_d     = state_q;
      main_data_d = main_data_q;
      main_tag_d  = main_tag_q;
      skid_data_d = skid_data_q;
      skid_tag_d  = skid_tag_q;
      case (state_q)
         EMPTY: if (accept) begin
            state_d     = ONE;
            main_data_d = res;
            main_tag_d  = in_tag;
         end
         ONE: if (accept && drain) begin
            main_data_d = res;
            main_tag_d  = in_tag;
         end else if (accept) begin
            state_d     = FULL;
            skid_data_d = res;
            skid_tag_d  = in_tag;
         end else if (drain) begin
            state_d = EMPTY;
         end
         FULL: if (drain) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_tag_d  = skid_tag_q;
         end
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
      in_ready_d = state_d != FULL;
   end

   // state and storage registers; reset clears everything and reopens the input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_tag_q  <= '0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_tag_q  <= main_tag_d;
         skid_data_q <= skid_data_d;
         skid_tag_q  <= skid_tag_d;
         in_ready_q  <= in_ready_d;
      end
   end
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: random and directed checks against a queue-based reference model
module tb_shift_exec_stage;
   localparam int TAG_W = 3;
   logic             clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [15:0]      in_data, out_data;
   logic [3:0]       in_cnt;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag, out_tag;

   typedef struct {
      logic [15:0]      d;
      logic [TAG_W-1:0] t;
   } ent_t;
   ent_t mq[$];
   int   xfer[$];
   int   checks = 0, errors = 0;
   logic last_acc;

   shift_exec_stage #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_shift(input logic [15:0] d, input int c, input logic [1:0] op);
      int x = int'(d);
      int r;
      case (op)
         2'd0:    r = (x << c) | (x >> (16 - c));
         2'd1:    r = x << c;
         2'd2:    r = (x >> c) | (x << (16 - c));
         default: r = x >> c;
      endcase
      return r[15:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() != 0) begin
         chk("out_data", 32'(out_data), 32'(mq[0].d));
         chk("out_tag", 32'(out_tag), 32'(mq[0].t));
      end
   endtask

   task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                        input logic [TAG_W-1:0] tg, input logic ordy, input logic fl, input logic r);
      logic acc, drn;
      in_valid  = v;
      in_data   = d;
      in_cnt    = c;
      in_op     = op;
      in_tag    = tg;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      acc       = v && mq.size() < 2;
      drn       = ordy && mq.size() > 0;
      if (out_valid === 1'b1 && ordy) xfer.push_back(int'(out_tag));
      last_acc = acc;
      @(posedge clk);
      if (r || fl) mq.delete();
      else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back('{ref_shift(d, int'(c), op), tg});
      end
      @(negedge clk);
      check_outputs();
   endtask

   logic [15:0] vd[7] = '{16'hA0A0, 16'h0001, 16'hFFFF, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
   logic [3:0]  vc[7] = '{4'd4, 4'd1, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
   logic [1:0]  vo[7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
   logic [15:0] ve[7] = '{16'h0A00, 16'h8000, 16'h0001, 16'h1234, 16'h1234, 16'h1234, 16'h1234};

   initial begin
      logic acc3;
      {rst, flush, in_valid, out_ready, in_data, in_cnt, in_op, in_tag} = '0;
      rst = 1'b1;
      @(negedge clk);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_tag", 32'(out_tag), 32'h0);

      cycle(1, 16'h8001, 4'd1, 2'd0, 3'd1, 1, 0, 0);
      chk("rol_valid", 32'(out_valid), 32'h1);
      chk("rol_data", 32'(out_data), 32'h0003);
      for (int i = 0; i < 7; i++) begin
         cycle(1, vd[i], vc[i], vo[i], 3'(i), 1, 0, 0);
         chk("vector", 32'(out_data), 32'(ve[i]));
      end
      cycle(0, 0, 0, 0, 0, 1, 0, 0);

      xfer.delete();
      cycle(1, 16'h0011, 4'd1, 2'd1, 3'd1, 0, 0, 0);
      cycle(1, 16'h0022, 4'd2, 2'd1, 3'd2, 0, 0, 0);
      chk("in_ready_full", 32'(in_ready), 32'h0);
      cycle(1, 16'h0033, 4'd3, 2'd1, 3'd3, 0, 0, 0);
      acc3 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(!acc3, 16'h0033, 4'd3, 2'd1, 3'd3, 1, 0, 0);
         if (last_acc) acc3 = 1'b1;
      end
      chk("xfer_count", 32'(xfer.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < xfer.size()) chk("xfer_order", 32'(xfer[i]), 32'(i + 1));

      cycle(1, 16'h0101, 4'd1, 2'd0, 3'd4, 0, 0, 0);
      cycle(1, 16'h0202, 4'd2, 2'd0, 3'd5, 0, 0, 0);
      cycle(1, 16'h0303, 4'd3, 2'd0, 3'd6, 0, 1, 0);
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_ready", 32'(in_ready), 32'h1);
      xfer.delete();
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0);
      chk("flush_no_xfer", 32'(xfer.size()), 32'd0);

      cycle(1, 16'h0404, 4'd1, 2'd3, 3'd1, 0, 0, 0);
      cycle(1, 16'h0505, 4'd2, 2'd3, 3'd2, 0, 0, 0);
      cycle(1, 16'h0606, 4'd3, 2'd3, 3'd3, 1, 0, 1);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h1);
      chk("rst_data", 32'(out_data), 32'h0);

      for (int i = 0; i < 5000; i++)
         cycle($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 2'($urandom), 3'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 499) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
